// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module      : uart_pkg
// Description : Shared types and defaults for the UART TX arbiter slice.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int unsigned c_BYTE_W           = 8;
  localparam int unsigned c_BUSY_WAIT_DEF    = 16;
  localparam int unsigned c_LOCK_TIMEOUT_DEF = 65535;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
//------------------------------------------------------------------------------
// Module      : uart_rr_pick
// Description : Combinational round-robin pick: first set request at or after
//               the pointer, wrapping, returned one-hot.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_any
);

  logic          w_found;
  int            w_idx;
  logic [PW-1:0] w_sel;

  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_sel = PW'(w_idx);
      if (!w_found && i_req[w_sel]) begin
        o_pick[w_sel] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module      : uart_tx_arbiter
// Description : Round-robin, frame-locked arbiter feeding one byte transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_WAIT    = c_BUSY_WAIT_DEF,
  parameter int LOCK_TIMEOUT = c_LOCK_TIMEOUT_DEF
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [c_BYTE_W*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      active_o,
  output logic [c_BYTE_W-1:0]       tx_data_o,
  output logic                      tx_shoot_o,
  input  logic                      tx_busy_i,
  output logic                      err_busy_o,
  output logic                      err_lock_o
);

  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(BUSY_WAIT + 1);
  localparam int LW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  localparam logic [BW-1:0] c_BUSY_LAST = BW'(BUSY_WAIT - 1);
  localparam logic [LW-1:0] c_LOCK_LAST = LW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam bit            c_LOCK_EN   = (LOCK_TIMEOUT != 0);

  state_t               r_state,    w_state;
  logic [PW-1:0]        r_ptr,      w_ptr;
  logic [PW-1:0]        r_gidx,     w_gidx;
  logic [N_REQ-1:0]     r_grant,    w_grant;
  logic [N_REQ-1:0]     r_ready,    w_ready;
  logic                 r_active,   w_active;
  logic                 r_last,     w_last;
  logic                 r_shoot,    w_shoot;
  logic                 r_err_busy, w_err_busy;
  logic                 r_err_lock, w_err_lock;
  logic [c_BYTE_W-1:0]  r_tx_data,  w_tx_data;
  logic [BW-1:0]        r_busy_cnt, w_busy_cnt;
  logic [LW-1:0]        r_lock_cnt, w_lock_cnt;

  logic [N_REQ-1:0]     w_pick;
  logic                 w_any;
  logic [PW-1:0]        w_pick_idx;
  logic [PW-1:0]        w_next_ptr;
  logic                 w_gvalid;
  logic [c_BYTE_W-1:0]  w_byte;
  logic                 w_done;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .i_req  (req_valid_i),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PW'(i);
    end
  end

  assign w_next_ptr = (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + PW'(1);
  assign w_gvalid   = req_valid_i[r_gidx];
  assign w_byte     = req_data_i[{r_gidx, 3'b000} +: c_BYTE_W];

  always_comb begin
    w_state    = r_state;
    w_ptr      = r_ptr;
    w_gidx     = r_gidx;
    w_grant    = r_grant;
    w_active   = r_active;
    w_last     = r_last;
    w_tx_data  = r_tx_data;
    w_busy_cnt = r_busy_cnt;
    w_lock_cnt = r_lock_cnt;
    w_shoot    = 1'b0;
    w_ready    = '0;
    w_err_busy = 1'b0;
    w_err_lock = 1'b0;
    w_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!r_active) begin
          if (w_any) begin
            w_gidx     = w_pick_idx;
            w_grant    = w_pick;
            w_active   = 1'b1;
            w_lock_cnt = '0;
            w_state    = S_ISSUE;
          end
        end else if (w_gvalid) begin
          w_state = S_ISSUE;
        end else if (c_LOCK_EN && (r_lock_cnt == c_LOCK_LAST)) begin
          // Grantee stalled mid-frame too long: give the UART to the others.
          w_err_lock = 1'b1;
          w_active   = 1'b0;
          w_grant    = '0;
          w_ptr      = w_next_ptr;
          w_lock_cnt = '0;
        end else begin
          w_lock_cnt = r_lock_cnt + LW'(1);
        end
      end

      S_ISSUE: begin
        if (w_gvalid && !tx_busy_i) begin
          w_tx_data  = w_byte;
          w_shoot    = 1'b1;
          w_ready    = r_grant;
          w_last     = req_last_i[r_gidx];
          w_busy_cnt = '0;
          w_state    = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (tx_busy_i) begin
          w_state = S_WAIT_DONE;
        end else if (r_busy_cnt == c_BUSY_LAST) begin
          w_err_busy = 1'b1;
          w_done     = 1'b1;
        end else begin
          w_busy_cnt = r_busy_cnt + BW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy_i) w_done = 1'b1;
      end

      default: w_state = S_IDLE;
    endcase

    // Byte finished (or presumed sent): release only at frame end.
    if (w_done) begin
      w_state    = S_IDLE;
      w_lock_cnt = '0;
      if (r_last) begin
        w_active = 1'b0;
        w_grant  = '0;
        w_ptr    = w_next_ptr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_grant    <= '0;
      r_ready    <= '0;
      r_active   <= 1'b0;
      r_last     <= 1'b0;
      r_shoot    <= 1'b0;
      r_err_busy <= 1'b0;
      r_err_lock <= 1'b0;
      r_tx_data  <= '0;
      r_busy_cnt <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_ptr      <= w_ptr;
      r_gidx     <= w_gidx;
      r_grant    <= w_grant;
      r_ready    <= w_ready;
      r_active   <= w_active;
      r_last     <= w_last;
      r_shoot    <= w_shoot;
      r_err_busy <= w_err_busy;
      r_err_lock <= w_err_lock;
      r_tx_data  <= w_tx_data;
      r_busy_cnt <= w_busy_cnt;
      r_lock_cnt <= w_lock_cnt;
    end
  end

  assign req_ready_o = r_ready;
  assign grant_o     = r_grant;
  assign active_o    = r_active;
  assign tx_data_o   = r_tx_data;
  assign tx_shoot_o  = r_shoot;
  assign err_busy_o  = r_err_busy;
  assign err_lock_o  = r_err_lock;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench: queue-based requesters, transmitter model
//               and a frame-level round-robin reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk_i = 1'b0;
  logic           resetn_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   grant_o;
  logic           active_o;
  logic [7:0]     tx_data_o;
  logic           tx_shoot_o;
  logic           tx_busy_i;
  logic           err_busy_o;
  logic           err_lock_o;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .BUSY_WAIT    (16),
    .LOCK_TIMEOUT (8)
  ) dut (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .active_o    (active_o),
    .tx_data_o   (tx_data_o),
    .tx_shoot_o  (tx_shoot_o),
    .tx_busy_i   (tx_busy_i),
    .err_busy_o  (err_busy_o),
    .err_lock_o  (err_lock_o)
  );

  int checks   = 0;
  int failures = 0;

  // Per-requester pending bytes: {last, data}
  logic [8:0] q [N][$];
  logic [7:0] shot_log[$];

  bit m_locked;
  int m_owner, m_ptr;
  int cyc, busy_left, busy_len;
  bit tx_en, rand_busy;
  int n_err_busy, n_err_lock, t_err_busy, t_err_lock, t_shoot;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid_i[i]       = 1'b1;
        req_data_i[8*i +: 8] = q[i][0][7:0];
        req_last_i[i]        = q[i][0][8];
      end else begin
        req_valid_i[i]       = 1'b0;
        req_last_i[i]        = 1'b0;
      end
    end
  endfunction

  // Owner of the next byte: the lock holder, else first pending requester from ptr.
  function automatic int model_owner();
    if (m_locked) return m_owner;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (q[j].size() > 0) return j;
    end
    return -1;
  endfunction

  function automatic logic [8:0] log_at(input int i);
    if (i < shot_log.size()) return {1'b0, shot_log[i]};
    return 9'h1FF;
  endfunction

  task automatic tick();
    int e;
    @(posedge clk_i);
    #1;
    cyc++;
    if (tx_shoot_o || (req_ready_o != '0)) begin
      e       = model_owner();
      t_shoot = cyc;
      check_eq("shoot_with_ready", 32'(tx_shoot_o), 32'd1);
      if (e < 0 || q[e].size() == 0) begin
        check_eq("ready_unexpected", 32'(req_ready_o), 32'd0);
      end else begin
        check_eq("ready_onehot", 32'(req_ready_o), 32'd1 << e);
        check_eq("grant_owner", 32'(grant_o), 32'd1 << e);
        check_eq("tx_data", 32'(tx_data_o), 32'(q[e][0][7:0]));
        if (q[e][0][8]) begin
          m_locked = 1'b0;
          m_ptr    = (e + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner  = e;
        end
        void'(q[e].pop_front());
      end
      shot_log.push_back(tx_data_o);
    end
    if (err_lock_o) begin
      n_err_lock++;
      t_err_lock = cyc;
      m_locked   = 1'b0;
      m_ptr      = (m_owner + 1) % N;
    end
    if (err_busy_o) begin
      n_err_busy++;
      t_err_busy = cyc;
    end
    if (tx_en && tx_shoot_o) busy_left = rand_busy ? $urandom_range(1, 5) : busy_len;
    tx_busy_i = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    drive_reqs();
  endtask

  task automatic do_reset();
    resetn_i = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    drive_reqs();
    busy_left = 0;
    tx_busy_i = 1'b0;
    m_locked  = 1'b0;
    m_ptr     = 0;
    shot_log.delete();
    repeat (2) @(posedge clk_i);
    #1;
    resetn_i = 1'b1;
  endtask

  task automatic wait_shots(input int n, input int bound, input string tag);
    int k;
    k = 0;
    while (shot_log.size() < n && k < bound) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(shot_log.size()), 32'(n));
  endtask

  initial begin
    logic [7:0] exp2 [5];
    logic [7:0] exp3 [4];
    int t0, k, base_b, base_l, len;
    logic [7:0] rb;

    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    tx_busy_i   = 1'b0;
    resetn_i    = 1'b0;
    cyc = 0; busy_left = 0; busy_len = 20; tx_en = 1'b1; rand_busy = 1'b0;
    n_err_busy = 0; n_err_lock = 0; t_err_busy = 0; t_err_lock = 0; t_shoot = 0;
    m_owner = 0;

    do_reset();
    check_eq("rst_grant", 32'(grant_o), 32'd0);
    check_eq("rst_active", 32'(active_o), 32'd0);
    check_eq("rst_shoot", 32'(tx_shoot_o), 32'd0);
    check_eq("rst_ready", 32'(req_ready_o), 32'd0);
    check_eq("rst_data", 32'(tx_data_o), 32'd0);
    check_eq("rst_errs", 32'({err_busy_o, err_lock_o}), 32'd0);
    repeat (3) tick();
    check_eq("idle_no_grant", 32'(grant_o), 32'd0);

    // Single-byte frame from requester 1, timing of grant/shoot/release
    q[1].push_back({1'b1, 8'hA5});
    drive_reqs();
    tick();
    check_eq("t1_grant", 32'(grant_o), 32'h2);
    check_eq("t1_active", 32'(active_o), 32'd1);
    check_eq("t1_no_shoot_yet", 32'(tx_shoot_o), 32'd0);
    tick();
    t0 = cyc;
    check_eq("t1_shoot", 32'(tx_shoot_o), 32'd1);
    check_eq("t1_ready", 32'(req_ready_o), 32'h2);
    check_eq("t1_data", 32'(tx_data_o), 32'hA5);
    tick();
    check_eq("t1_shoot_one_cycle", 32'(tx_shoot_o), 32'd0);
    check_eq("t1_data_hold", 32'(tx_data_o), 32'hA5);
    k = 0;
    while (active_o && k < 60) begin tick(); k++; end
    check_eq("t1_release_cycles", 32'(cyc - t0), 32'd21);
    check_eq("t1_grant_cleared", 32'(grant_o), 32'd0);

    // Pointer now 2: requester 2 wins over requester 0
    busy_len = 2;
    shot_log.delete();
    q[0].push_back({1'b1, 8'h50});
    q[2].push_back({1'b1, 8'h52});
    drive_reqs();
    wait_shots(2, 100, "ptr_shots");
    check_eq("ptr_first", 32'(log_at(0)), 32'h52);
    check_eq("ptr_second", 32'(log_at(1)), 32'h50);

    // All four requesting single-byte frames
    do_reset();
    exp2 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    q[0].push_back({1'b1, 8'h10});
    q[0].push_back({1'b1, 8'h10});
    q[1].push_back({1'b1, 8'h11});
    q[2].push_back({1'b1, 8'h12});
    q[3].push_back({1'b1, 8'h13});
    drive_reqs();
    wait_shots(5, 300, "t2_shots");
    for (int i = 0; i < 5; i++) check_eq($sformatf("t2_order%0d", i), 32'(log_at(i)), 32'(exp2[i]));

    // Multi-byte frame is not interleaved
    do_reset();
    exp3 = '{8'h01, 8'h02, 8'h03, 8'h20};
    q[0].push_back({1'b0, 8'h01});
    q[0].push_back({1'b0, 8'h02});
    q[0].push_back({1'b1, 8'h03});
    q[2].push_back({1'b1, 8'h20});
    drive_reqs();
    wait_shots(4, 300, "t3_shots");
    for (int i = 0; i < 4; i++) check_eq($sformatf("t3_order%0d", i), 32'(log_at(i)), 32'(exp3[i]));

    // Lock timeout: requester 3 stalls after its first byte
    do_reset();
    base_l = n_err_lock;
    q[3].push_back({1'b0, 8'h31});
    drive_reqs();
    wait_shots(1, 50, "t4_first");
    q[0].push_back({1'b1, 8'h40});
    q[1].push_back({1'b1, 8'h41});
    drive_reqs();
    k = 0;
    while (n_err_lock == base_l && k < 40) begin tick(); k++; end
    check_eq("t4_lock_delay", 32'(t_err_lock - t_shoot), 32'd11);
    check_eq("t4_grant_dropped", 32'(grant_o), 32'd0);
    wait_shots(3, 100, "t4_after");
    check_eq("t4_next_req0", 32'(log_at(1)), 32'h40);
    check_eq("t4_then_req1", 32'(log_at(2)), 32'h41);
    check_eq("t4_lock_once", 32'(n_err_lock - base_l), 32'd1);

    // Transmitter never goes busy
    do_reset();
    base_b = n_err_busy;
    tx_en  = 1'b0;
    q[2].push_back({1'b1, 8'h62});
    drive_reqs();
    wait_shots(1, 50, "t5_first");
    k = 0;
    while (n_err_busy == base_b && k < 40) begin tick(); k++; end
    check_eq("t5_busy_delay", 32'(t_err_busy - t_shoot), 32'd16);
    tx_en    = 1'b1;
    busy_len = 3;
    q[1].push_back({1'b1, 8'h71});
    drive_reqs();
    wait_shots(2, 100, "t5_next");
    check_eq("t5_served", 32'(log_at(1)), 32'h71);
    check_eq("t5_busy_once", 32'(n_err_busy - base_b), 32'd1);

    // Asynchronous reset in WAIT_DONE
    do_reset();
    busy_len = 20;
    q[2].push_back({1'b0, 8'h81});
    q[2].push_back({1'b1, 8'h82});
    drive_reqs();
    wait_shots(1, 50, "t6_first");
    repeat (3) tick();
    check_eq("t6_active_before", 32'(active_o), 32'd1);
    #2;
    resetn_i = 1'b0;
    #1;
    check_eq("t6_async_grant", 32'(grant_o), 32'd0);
    check_eq("t6_async_active", 32'(active_o), 32'd0);
    check_eq("t6_async_data", 32'(tx_data_o), 32'd0);
    base_b = n_err_busy;
    base_l = n_err_lock;
    do_reset();
    repeat (30) tick();
    check_eq("t6_no_err", 32'((n_err_busy - base_b) + (n_err_lock - base_l)), 32'd0);
    busy_len = 2;
    q[3].push_back({1'b1, 8'h93});
    q[0].push_back({1'b1, 8'h90});
    drive_reqs();
    wait_shots(2, 100, "t6_shots");
    check_eq("t6_ptr_zero", 32'(log_at(0)), 32'h90);
    check_eq("t6_then_3", 32'(log_at(1)), 32'h93);

    // Randomized frames against the reference model
    do_reset();
    rand_busy = 1'b1;
    base_b = n_err_busy;
    base_l = n_err_lock;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            rb = 8'($urandom);
            q[i].push_back({(b == len - 1), rb});
          end
        end
      end
      drive_reqs();
      k = 0;
      while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || active_o) && k < 2000) begin
        tick();
        k++;
      end
      check_eq($sformatf("rand_drain%0d", r), 32'(active_o), 32'd0);
    end
    check_eq("rand_no_err", 32'((n_err_busy - base_b) + (n_err_lock - base_l)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
